// File: rtl/frame_cropper_pkg.sv
// Shared types and helpers for the frame cropper.
// State encodings are plain localparams so legacy tools can consume them.
package frame_cropper_pkg;

    typedef logic [1:0] frame_crop_state_t;

    localparam frame_crop_state_t IDLE_S     = 2'd0;
    localparam frame_crop_state_t CROP_TOP_S = 2'd1;
    localparam frame_crop_state_t PASS_S     = 2'd2;
    localparam frame_crop_state_t CROP_BOT_S = 2'd3;

    function automatic int calc_tdata_width(input int px_width);
        return ((px_width + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/crop_axis_reg.sv
// Single-stage AXI4-Stream output register. Beats with keep_i low are consumed
// without producing output; tuser/tlast come from the caller, not the input bus.
module crop_axis_reg #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                inValid_i,
    output logic                inReady_o,
    input  logic                keep_i,
    input  logic                tuser_i,
    input  logic                tlast_i,
    input  logic [DATA_W-1:0]   inData_i,
    input  logic [DATA_W/8-1:0] inStrb_i,
    input  logic [DATA_W/8-1:0] inKeep_i,
    input  logic [ID_W-1:0]     inId_i,
    input  logic [DEST_W-1:0]   inDest_i,
    output logic                outValid_o,
    input  logic                outReady_i,
    output logic                outUser_o,
    output logic                outLast_o,
    output logic [DATA_W-1:0]   outData_o,
    output logic [DATA_W/8-1:0] outStrb_o,
    output logic [DATA_W/8-1:0] outKeep_o,
    output logic [ID_W-1:0]     outId_o,
    output logic [DEST_W-1:0]   outDest_o
);

    logic                valid_q;
    logic                user_q;
    logic                last_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] strb_q;
    logic [DATA_W/8-1:0] keep_q;
    logic [ID_W-1:0]     id_q;
    logic [DEST_W-1:0]   dest_q;
    logic                load;

    always_comb begin
        inReady_o = !valid_q || outReady_i;
        load      = inValid_i && inReady_o && keep_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            keep_q  <= '0;
            id_q    <= '0;
            dest_q  <= '0;
        end else if (inReady_o) begin
            valid_q <= inValid_i && keep_i;
            if (load) begin
                user_q <= tuser_i;
                last_q <= tlast_i;
                data_q <= inData_i;
                strb_q <= inStrb_i;
                keep_q <= inKeep_i;
                id_q   <= inId_i;
                dest_q <= inDest_i;
            end
        end
    end

    assign outValid_o = valid_q;
    assign outUser_o  = user_q;
    assign outLast_o  = last_q;
    assign outData_o  = data_q;
    assign outStrb_o  = strb_q;
    assign outKeep_o  = keep_q;
    assign outId_o    = id_q;
    assign outDest_o  = dest_q;

endmodule

// File: rtl/frame_cropper.sv
// Strips TOP/BOTTOM lines and LEFT/RIGHT pixels from a fixed-geometry video stream.
// Define FRAME_CROPPER_STATS_EN to add completed-frame and malformed-line counters.
module frame_cropper
    import frame_cropper_pkg::*;
#(
    parameter int TOP         = 1,
    parameter int BOTTOM      = 1,
    parameter int LEFT        = 1,
    parameter int RIGHT       = 1,
    parameter int FRAME_RES_X = 1922,
    parameter int FRAME_RES_Y = 1082,
    parameter int PX_WIDTH    = 10,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    localparam int TDATA_WIDTH = calc_tdata_width(PX_WIDTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     inTvalid_i,
    output logic                     inTready_o,
    input  logic                     inTuser_i,
    input  logic                     inTlast_i,
    input  logic [TDATA_WIDTH-1:0]   inTdata_i,
    input  logic [TDATA_WIDTH/8-1:0] inTstrb_i,
    input  logic [TDATA_WIDTH/8-1:0] inTkeep_i,
    input  logic [TID_WIDTH-1:0]     inTid_i,
    input  logic [TDEST_WIDTH-1:0]   inTdest_i,
    output logic                     outTvalid_o,
    input  logic                     outTready_i,
    output logic                     outTuser_o,
    output logic                     outTlast_o,
    output logic [TDATA_WIDTH-1:0]   outTdata_o,
    output logic [TDATA_WIDTH/8-1:0] outTstrb_o,
    output logic [TDATA_WIDTH/8-1:0] outTkeep_o,
    output logic [TID_WIDTH-1:0]     outTid_o,
    output logic [TDEST_WIDTH-1:0]   outTdest_o
`ifdef FRAME_CROPPER_STATS_EN
    ,
    output logic [31:0]              frames_o,
    output logic [31:0]              malformed_o
`endif
);

    localparam int XW = $clog2(FRAME_RES_X + 1);
    localparam int YW = $clog2(FRAME_RES_Y + 1);

    localparam logic [XW-1:0] LEFT_X      = XW'(LEFT);
    localparam logic [XW-1:0] KEEP_END_X  = XW'(FRAME_RES_X - RIGHT);
    localparam logic [XW-1:0] LAST_KEEP_X = XW'(FRAME_RES_X - RIGHT - 1);
    localparam logic [XW-1:0] MAX_X       = XW'(FRAME_RES_X);
    localparam logic [YW-1:0] TOP_LAST_Y   = YW'(TOP > 0 ? TOP - 1 : 0);
    localparam logic [YW-1:0] PASS_LAST_Y  = YW'(FRAME_RES_Y - BOTTOM - 1);
    localparam logic [YW-1:0] FRAME_LAST_Y = YW'(FRAME_RES_Y - 1);

    localparam frame_crop_state_t SOF_STATE = (TOP > 0) ? CROP_TOP_S : PASS_S;
    localparam frame_crop_state_t PASS_EXIT = (BOTTOM > 0) ? CROP_BOT_S : IDLE_S;

    frame_crop_state_t state_q, state_d, curState;
    logic [XW-1:0]     xCnt_q, xCnt_d, curX;
    logic [YW-1:0]     yCnt_q, yCnt_d, curY;
    logic              firstPend_q, firstPend_d;
    logic              accept, keep, beatUser, beatLast;

    // A tuser beat restarts the frame wherever we are, so it is decoded as pixel 0 of line 0.
    always_comb begin
        accept   = inTvalid_i && inTready_o;
        curState = inTuser_i ? SOF_STATE : state_q;
        curX     = inTuser_i ? '0 : xCnt_q;
        curY     = inTuser_i ? '0 : yCnt_q;
        keep     = (curState == PASS_S) && (curX >= LEFT_X) && (curX < KEEP_END_X);
        beatUser = keep && (inTuser_i || firstPend_q);
        beatLast = inTlast_i || (curX == LAST_KEEP_X);
    end

    always_comb begin
        state_d     = state_q;
        xCnt_d      = xCnt_q;
        yCnt_d      = yCnt_q;
        firstPend_d = firstPend_q;
        if (accept && (curState != IDLE_S)) begin
            state_d     = curState;
            firstPend_d = (inTuser_i || firstPend_q) && !keep;
            xCnt_d      = inTlast_i ? '0 : ((curX == MAX_X) ? curX : curX + 1'b1);
            yCnt_d      = inTlast_i ? curY + 1'b1 : curY;
            if (inTlast_i) begin
                case (curState)
                    CROP_TOP_S: if (curY == TOP_LAST_Y)   state_d = PASS_S;
                    PASS_S:     if (curY == PASS_LAST_Y)  state_d = PASS_EXIT;
                    CROP_BOT_S: if (curY == FRAME_LAST_Y) state_d = IDLE_S;
                    default:    state_d = curState;
                endcase
            end
            if (state_d == IDLE_S) begin
                xCnt_d = '0;
                yCnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE_S;
            xCnt_q      <= '0;
            yCnt_q      <= '0;
            firstPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xCnt_q      <= xCnt_d;
            yCnt_q      <= yCnt_d;
            firstPend_q <= firstPend_d;
        end
    end

    crop_axis_reg #(
        .DATA_W (TDATA_WIDTH),
        .ID_W   (TID_WIDTH),
        .DEST_W (TDEST_WIDTH)
    ) u_outReg (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .inValid_i  (inTvalid_i),
        .inReady_o  (inTready_o),
        .keep_i     (keep),
        .tuser_i    (beatUser),
        .tlast_i    (beatLast),
        .inData_i   (inTdata_i),
        .inStrb_i   (inTstrb_i),
        .inKeep_i   (inTkeep_i),
        .inId_i     (inTid_i),
        .inDest_i   (inTdest_i),
        .outValid_o (outTvalid_o),
        .outReady_i (outTready_i),
        .outUser_o  (outTuser_o),
        .outLast_o  (outTlast_o),
        .outData_o  (outTdata_o),
        .outStrb_o  (outTstrb_o),
        .outKeep_o  (outTkeep_o),
        .outId_o    (outTid_o),
        .outDest_o  (outTdest_o)
    );

`ifdef FRAME_CROPPER_STATS_EN
    localparam logic [XW-1:0] LAST_X = XW'(FRAME_RES_X - 1);

    logic [31:0] frames_q, malformed_q;
    logic        frameDone, badLine, resync;

    // A resync is only malformed when it interrupts a frame already in progress.
    always_comb begin
        frameDone = accept && ((curState == PASS_S) || (curState == CROP_BOT_S)) && (state_d == IDLE_S);
        badLine   = accept && (curState != IDLE_S) && inTlast_i && (curX != LAST_X);
        resync    = accept && inTuser_i && (state_q != IDLE_S);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frames_q    <= '0;
            malformed_q <= '0;
        end else begin
            frames_q    <= frames_q + {31'd0, frameDone};
            malformed_q <= malformed_q + {31'd0, badLine} + {31'd0, resync};
        end
    end

    assign frames_o    = frames_q;
    assign malformed_o = malformed_q;
`endif

endmodule

// File: tb/tb_frame_cropper.sv
// Directed bench for frame_cropper on an 8x6 frame cropped to 5x4 (TOP=BOTTOM=1, LEFT=2, RIGHT=1).
module tb_frame_cropper;

    localparam int RES_X = 8;
    localparam int RES_Y = 6;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inTvalid, inTready, inTuser, inTlast;
    logic [15:0] inTdata;
    logic        outTvalid, outTready, outTuser, outTlast;
    logic [15:0] outTdata;
    logic [1:0]  outTstrb, outTkeep;
    logic        outTid, outTdest;
`ifdef FRAME_CROPPER_STATS_EN
    logic [31:0] framesCnt, malformedCnt;
`endif

    always #5 clk = ~clk;

    frame_cropper #(
        .TOP(1), .BOTTOM(1), .LEFT(2), .RIGHT(1),
        .FRAME_RES_X(RES_X), .FRAME_RES_Y(RES_Y), .PX_WIDTH(10)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .inTvalid_i  (inTvalid),
        .inTready_o  (inTready),
        .inTuser_i   (inTuser),
        .inTlast_i   (inTlast),
        .inTdata_i   (inTdata),
        .inTstrb_i   (2'b11),
        .inTkeep_i   (2'b11),
        .inTid_i     (1'b0),
        .inTdest_i   (1'b0),
        .outTvalid_o (outTvalid),
        .outTready_i (outTready),
        .outTuser_o  (outTuser),
        .outTlast_o  (outTlast),
        .outTdata_o  (outTdata),
        .outTstrb_o  (outTstrb),
        .outTkeep_o  (outTkeep),
        .outTid_o    (outTid),
        .outTdest_o  (outTdest)
`ifdef FRAME_CROPPER_STATS_EN
        ,
        .frames_o    (framesCnt),
        .malformed_o (malformedCnt)
`endif
    );

    typedef struct {
        logic        vld;
        logic        sof;
        logic        eol;
        logic [15:0] data;
        logic        expVld;
        logic        expSof;
        logic        expEol;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs[$];
    int   vecCount  = 0;
    int   missCount = 0;
    int   runId     = 0;

    function automatic logic [15:0] pix(input int fid, input int y, input int x);
        return 16'((fid << 8) | (y << 4) | x);
    endfunction

    // Cropped window of the 8x6 frame: lines 1..4, columns 2..6.
    function automatic bit inWindow(input int y, input int x);
        return (y >= 1) && (y <= 4) && (x >= 2) && (x <= 6);
    endfunction

    task automatic addBeats(input int fid, input int y, input int xFrom, input int xTo,
                            input int lineLen, input bit sofFirst, input bit live);
        for (int x = xFrom; x <= xTo; x++) begin
            vec_t v;
            v.vld     = 1'b1;
            v.sof     = sofFirst && (x == xFrom);
            v.eol     = (x == lineLen - 1);
            v.data    = pix(fid, y, x);
            v.expVld  = live && inWindow(y, x);
            v.expSof  = v.expVld && (y == 1) && (x == 2);
            v.expEol  = v.expVld && ((x == 6) || v.eol);
            v.expData = v.expVld ? v.data : 16'h0;
            vecs.push_back(v);
        end
    endtask

    task automatic addFrame(input int fid, input int shortY, input int shortLen);
        for (int y = 0; y < RES_Y; y++) begin
            int len;
            len = (y == shortY) ? shortLen : RES_X;
            addBeats(fid, y, 0, len - 1, len, y == 0, 1'b1);
        end
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0};
            vecs.push_back(v);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        inTvalid = v.vld;
        inTuser  = v.sof;
        inTlast  = v.eol;
        inTdata  = v.data;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        bit ok;
        vecCount++;
        ok = (outTvalid === v.expVld) &&
             (!v.expVld || ((outTuser === v.expSof) && (outTlast === v.expEol) && (outTdata === v.expData)));
        if (!ok) begin
            missCount++;
            $display("[TB] FAIL run%0d vec%0d: got v=%b u=%b l=%b d=%h, want v=%b u=%b l=%b d=%h",
                     runId, idx, outTvalid, outTuser, outTlast, outTdata,
                     v.expVld, v.expSof, v.expEol, v.expData);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        vecCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic runTable();
        runId++;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i], i);
        end
        vecs.delete();
    endtask

    // Consumer stalls at random; output must match the geometric order exactly once each.
    task automatic runRandomReady();
        vec_t        inQ[$];
        vec_t        expQ[$];
        vec_t        e;
        int          idx = 0;
        int          cycles = 0;
        bit          prevStall = 0;
        bit          inAcc, outAcc;
        logic [15:0] prevData = 16'h0;
        logic        prevSof = 1'b0, prevEol = 1'b0;
        inQ = vecs;
        vecs.delete();
        foreach (inQ[i]) if (inQ[i].expVld) expQ.push_back(inQ[i]);
        while (((idx < inQ.size()) || (expQ.size() > 0)) && (cycles < 2000)) begin
            if (idx < inQ.size()) applyStimulus(inQ[idx]);
            else inTvalid = 1'b0;
            outTready = 1'($urandom_range(0, 1));
            @(negedge clk);
            inAcc  = inTvalid && inTready;
            outAcc = outTvalid && outTready;
            if (prevStall) begin
                vecCount++;
                if (!(outTvalid && (outTdata == prevData) && (outTuser == prevSof) && (outTlast == prevEol))) begin
                    missCount++;
                    $display("[TB] FAIL stallHold: got v=%b d=%h, want v=1 d=%h", outTvalid, outTdata, prevData);
                end
            end
            if (outAcc) begin
                vecCount++;
                if (expQ.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL extraBeat: got d=%h, want no beat", outTdata);
                end else begin
                    e = expQ.pop_front();
                    if ((outTdata !== e.expData) || (outTuser !== e.expSof) || (outTlast !== e.expEol)) begin
                        missCount++;
                        $display("[TB] FAIL randBeat: got u=%b l=%b d=%h, want u=%b l=%b d=%h",
                                 outTuser, outTlast, outTdata, e.expSof, e.expEol, e.expData);
                    end
                end
            end
            prevStall = outTvalid && !outTready;
            prevData  = outTdata;
            prevSof   = outTuser;
            prevEol   = outTlast;
            @(posedge clk);
            #1;
            if (inAcc) idx++;
            cycles++;
        end
        checkValue("randDrained", 32'(expQ.size()), 32'd0);
        checkValue("randInputsTaken", 32'(idx), 32'(inQ.size()));
        inTvalid  = 1'b0;
        outTready = 1'b1;
        @(negedge clk);
        checkValue("randNoTrailing", {31'd0, outTvalid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN      = 1'b0;
        inTvalid  = 1'b0;
        inTuser   = 1'b0;
        inTlast   = 1'b0;
        inTdata   = 16'h0;
        outTready = 1'b1;

        #22;
        checkValue("rstValid", {31'd0, outTvalid}, 32'd0);
        checkValue("rstUser",  {31'd0, outTuser},  32'd0);
        checkValue("rstLast",  {31'd0, outTlast},  32'd0);
        checkValue("rstData",  {16'd0, outTdata},  32'd0);
        checkValue("rstReady", {31'd0, inTready},  32'd1);
        #1 rstN = 1'b1;
        @(posedge clk);
        #1;

        // Orphan beats before any tuser, then clean, short-line, truncated and resync frames.
        addBeats(9, 2, 0, 7, RES_X, 1'b0, 1'b0);
        addBeats(9, 3, 0, 1, RES_X, 1'b0, 1'b0);
        addFrame(1, -1, 0);
        addFrame(2, 2, 5);
        addBeats(3, 0, 0, 7, RES_X, 1'b1, 1'b1);
        addBeats(3, 1, 0, 7, RES_X, 1'b0, 1'b1);
        addBeats(3, 2, 0, 7, RES_X, 1'b0, 1'b1);
        addBeats(3, 3, 0, 4, RES_X, 1'b0, 1'b1);
        addFrame(4, -1, 0);
        addIdle(2);
        $display("[TB] table run: %0d vectors", vecs.size());
        runTable();
`ifdef FRAME_CROPPER_STATS_EN
        checkValue("statFrames",    framesCnt,    32'd3);
        checkValue("statMalformed", malformedCnt, 32'd2);
`endif

        $display("[TB] random backpressure frame");
        addFrame(5, -1, 0);
        runRandomReady();

        $display("[TB] reset in the middle of line 2");
        addBeats(6, 0, 0, 7, RES_X, 1'b1, 1'b1);
        addBeats(6, 1, 0, 7, RES_X, 1'b0, 1'b1);
        addBeats(6, 2, 0, 3, RES_X, 1'b0, 1'b1);
        runTable();
        checkValue("preRstValid", {31'd0, outTvalid}, 32'd1);
        #2;
        rstN     = 1'b0;
        inTvalid = 1'b0;
        #1;
        checkValue("midRstValid", {31'd0, outTvalid}, 32'd0);
        checkValue("midRstUser",  {31'd0, outTuser},  32'd0);
        checkValue("midRstLast",  {31'd0, outTlast},  32'd0);
        checkValue("midRstData",  {16'd0, outTdata},  32'd0);
        @(posedge clk);
        #3 rstN = 1'b1;
        @(posedge clk);
        #1;
        addBeats(6, 2, 4, 7, RES_X, 1'b0, 1'b0);
        for (int y = 3; y < RES_Y; y++) addBeats(6, y, 0, 7, RES_X, 1'b0, 1'b0);
        addFrame(7, -1, 0);
        addIdle(2);
        runTable();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
